tmr_fault_manager: RTL

Sequential controller for the triple-modular-redundant execute stage. It consumes per-lane disagreement flags from the majority voter and decides when to request re-execution. It tracks per-lane error history, retires a persistently faulty lane by masking it (degraded dual mode), and escalates to a sticky fatal state when redundancy is exhausted. It sits beside the voter, driving the pipeline's retry/flush handshake and the core's fault interrupt.

---
 rtl/tmr_fault_manager_pkg.sv | 26 ++
 rtl/tmr_fault_manager_lane_counter.sv | 44 ++++
 rtl/tmr_fault_manager.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tmr_fault_manager_pkg.sv
// tmr_fault_manager_pkg
// Shared types and constants for the TMR fault manager: controller state
// encoding, lane indices, error-counter width and a helper that counts how
// many lanes have hit the masking threshold.
package tmr_fault_manager_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_RETRY    = 2'd1,
    ST_DEGRADED = 2'd2,
    ST_FAIL     = 2'd3
  } tmr_state_e;

  localparam int LANE_A    = 0;
  localparam int LANE_B    = 1;
  localparam int LANE_C    = 2;
  localparam int NUM_LANES = 3;

  // Wide enough for any threshold in 2..7.
  localparam int CNT_W = 3;

  function automatic logic [1:0] count_ones3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/tmr_fault_manager_lane_counter.sv
// tmr_lane_counter
// Per-lane error history counter. Counts up on inc and saturates at
// THRESHOLD. Counts down on dec and holds at zero. clr has priority over
// inc, and inc has priority over dec.
//
// Ports
//   clk           core clock
//   reset_n       asynchronous, active-low reset
//   inc           count one error on this lane
//   dec           decay step, applied only while the count is nonzero
//   clr           force the count to zero
//   count         current error count
//   at_threshold  count has reached THRESHOLD
module tmr_lane_counter
  import tmr_fault_manager_pkg::*;
#(
  parameter int THRESHOLD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             at_threshold
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(THRESHOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      if (count < SAT) count <= count + 1'b1;
    end else if (dec) begin
      if (count != '0) count <= count - 1'b1;
    end
  end

  assign at_threshold = (count == SAT);

endmodule

// File: rtl/tmr_fault_manager.sv
// tmr_fault_manager
// Sequential controller beside the TMR majority voter. It counts per-lane
// disagreements, requests re-execution on each error, and masks a lane that
// keeps failing (degraded dual mode). When redundancy is exhausted it enters
// a sticky fatal state.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// NORMAL   | all lanes voting; counting errors, decaying on clean checks
// RETRY    | retry_req_o held until the pipeline acks the flush
// DEGRADED | one lane masked; any further effective error is fatal
// FAIL     | sticky; only reset_n leaves this state
//
// Ports
//   clk            core clock
//   reset_n        asynchronous, active-low reset
//   check_valid_i  voter result committed this cycle
//   lane_err_i     per-lane disagreement flags {c, b, a}
//   no_majority_i  all three lanes differ pairwise
//   retry_ack_i    pipeline flushed and will re-execute
//   clear_i        software clear (ignored in FAIL)
//   retry_req_o    re-execute request, held until acked
//   lane_mask_o    lanes excluded from comparison
//   degraded_o     controller is in DEGRADED
//   fatal_o        sticky uncorrectable failure
//   irq_o          one-cycle pulse on entry to DEGRADED or FAIL
//   err_count_o    {cnt_c, cnt_b, cnt_a}
module tmr_fault_manager
  import tmr_fault_manager_pkg::*;
#(
  parameter int THRESHOLD    = 4,
  parameter int DECAY_WINDOW = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         check_valid_i,
  input  logic [NUM_LANES-1:0]         lane_err_i,
  input  logic                         no_majority_i,
  input  logic                         retry_ack_i,
  input  logic                         clear_i,
  output logic                         retry_req_o,
  output logic [NUM_LANES-1:0]         lane_mask_o,
  output logic                         degraded_o,
  output logic                         fatal_o,
  output logic                         irq_o,
  output logic [NUM_LANES*CNT_W-1:0]   err_count_o
);

  localparam int                WIN_W    = $clog2(DECAY_WINDOW);
  localparam logic [WIN_W-1:0]  WIN_LOAD = WIN_W'(DECAY_WINDOW - 1);

  tmr_state_e state;

  // Clean checks remaining before the next decay step. Reloading to
  // DECAY_WINDOW-1 means decay fires on the DECAY_WINDOW-th consecutive
  // clean check.
  logic [WIN_W-1:0] win_left;

  logic                              eff_err;
  logic                              clear_ok;
  logic                              decay_now;
  logic                              cnt_clr;
  logic                              cnt_dec;
  logic [NUM_LANES-1:0]              cnt_inc;
  logic [NUM_LANES-1:0]              at_thr;
  logic [NUM_LANES-1:0][CNT_W-1:0]   cnt;
  logic [1:0]                        n_at_thr;

  assign eff_err   = check_valid_i &
                     ((|(lane_err_i & ~lane_mask_o)) | no_majority_i);
  assign clear_ok  = clear_i & (state != ST_FAIL);
  assign decay_now = check_valid_i & ~eff_err & (win_left == '0);
  assign n_at_thr  = count_ones3(at_thr);

  // Counters only move in NORMAL. DEGRADED freezes them so the history that
  // caused the mask stays visible to software.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = '0;
    cnt_dec = 1'b0;
    if (clear_ok) begin
      cnt_clr = 1'b1;
    end else if (state == ST_NORMAL) begin
      if (eff_err) begin
        cnt_inc = no_majority_i ? '1 : (lane_err_i & ~lane_mask_o);
      end else if (decay_now) begin
        cnt_dec = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tmr_lane_counter #(
      .THRESHOLD (THRESHOLD)
    ) u_cnt (
      .clk          (clk),
      .reset_n      (reset_n),
      .inc          (cnt_inc[i]),
      .dec          (cnt_dec),
      .clr          (cnt_clr),
      .count        (cnt[i]),
      .at_threshold (at_thr[i])
    );
  end

  assign err_count_o = cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_NORMAL;
      win_left    <= WIN_LOAD;
      retry_req_o <= 1'b0;
      lane_mask_o <= '0;
      degraded_o  <= 1'b0;
      fatal_o     <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      irq_o <= 1'b0;
      if (clear_ok) begin
        state       <= ST_NORMAL;
        win_left    <= WIN_LOAD;
        retry_req_o <= 1'b0;
        lane_mask_o <= '0;
        degraded_o  <= 1'b0;
      end else begin
        case (state)
          ST_NORMAL: begin
            if (eff_err) begin
              state       <= ST_RETRY;
              retry_req_o <= 1'b1;
              win_left    <= WIN_LOAD;
            end else if (check_valid_i) begin
              win_left <= decay_now ? WIN_LOAD : win_left - 1'b1;
            end
          end

          ST_RETRY: begin
            if (retry_ack_i) begin
              retry_req_o <= 1'b0;
              case (n_at_thr)
                2'd0: state <= ST_NORMAL;
                2'd1: begin
                  // Mask is all-zero in NORMAL/RETRY, so at_thr is the mask.
                  state       <= ST_DEGRADED;
                  lane_mask_o <= at_thr;
                  degraded_o  <= 1'b1;
                  irq_o       <= 1'b1;
                end
                default: begin
                  state   <= ST_FAIL;
                  fatal_o <= 1'b1;
                  irq_o   <= 1'b1;
                end
              endcase
            end
          end

          ST_DEGRADED: begin
            if (eff_err) begin
              state      <= ST_FAIL;
              degraded_o <= 1'b0;
              fatal_o    <= 1'b1;
              irq_o      <= 1'b1;
            end
          end

          ST_FAIL: begin
          end

          default: state <= ST_FAIL;
        endcase
      end
    end
  end

endmodule
